// File: rtl/mastermind_pkg.sv
// Shared Mastermind types: guess-timer FSM states and the BCD digit width.
package mastermind_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } guess_timer_state_t;

endpackage

// File: rtl/mastermind_guess_timer_if.sv
// Control and status bundle between the game controller (master) and the guess timer (slave).
interface mastermind_guess_timer_if
  import mastermind_pkg::*;
#(
  parameter int unsigned SEC_W = 7
);
  logic               tick;
  logic               start;
  logic               pause;
  logic               guess_done;
  logic [SEC_W-1:0]   secs_left;
  logic [DIGIT_W-1:0] bcd_tens;
  logic [DIGIT_W-1:0] bcd_ones;
  logic               running;
  logic               expired;
  logic               timeout;
  logic               warn;

  modport master (
    output tick, start, pause, guess_done,
    input  secs_left, bcd_tens, bcd_ones, running, expired, timeout, warn
  );

  modport slave (
    input  tick, start, pause, guess_done,
    output secs_left, bcd_tens, bcd_ones, running, expired, timeout, warn
  );
endinterface

// File: rtl/mastermind_bin2bcd.sv
// Combinational binary (0..99) to two BCD digits; shared with the score display.
module mastermind_bin2bcd
  import mastermind_pkg::*;
#(
  parameter int unsigned BIN_W = 7
) (
  input  logic [BIN_W-1:0]   bin,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones
);
  int unsigned val;

  always_comb begin
    val  = 32'(bin);
    tens = DIGIT_W'(val / 10);
    ones = DIGIT_W'(val % 10);
  end
endmodule

// File: rtl/mastermind_guess_timer.sv
// Per-guess countdown timer: tick prescaler, seconds countdown, timeout pulse and warn.
// Define WARN_BLINK_EN to make warn blink once per second instead of holding steady.
module mastermind_guess_timer
  import mastermind_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 5,
  parameter int unsigned TIME_LIMIT    = 30,
  parameter int unsigned WARN_THRESH   = 5,
  parameter int unsigned SEC_W         = 7
) (
  input logic                     clock,
  input logic                     reset_n,
  mastermind_guess_timer_if.slave bus
);
  localparam int unsigned PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  guess_timer_state_t state_q, state_d;
  logic [SEC_W-1:0]   secs_q, secs_d;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic               timeout_q, timeout_d;
  logic               warn_q, warn_d;
  logic               warn_cond;
  logic               sec_edge;

  // Priority: start > guess_done > pause > tick.
  always_comb begin
    state_d   = state_q;
    secs_d    = secs_q;
    presc_d   = presc_q;
    timeout_d = 1'b0;
    sec_edge  = 1'b0;
    if (bus.start) begin
      secs_d  = SEC_W'(TIME_LIMIT);
      presc_d = '0;
      state_d = bus.pause ? PAUSED : RUNNING;
    end else if (bus.guess_done && (state_q == RUNNING || state_q == PAUSED)) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        RUNNING: begin
          if (bus.pause) begin
            state_d = PAUSED;
          end else if (bus.tick) begin
            if (presc_q == PRE_W'(TICKS_PER_SEC - 1)) begin
              presc_d  = '0;
              sec_edge = 1'b1;
              if (secs_q <= SEC_W'(1)) begin
                secs_d    = '0;
                state_d   = EXPIRED;
                timeout_d = 1'b1;
              end else begin
                secs_d = secs_q - SEC_W'(1);
              end
            end else begin
              presc_d = presc_q + PRE_W'(1);
            end
          end
        end
        PAUSED:  if (!bus.pause) state_d = RUNNING;
        default: ;
      endcase
    end
  end

  // Evaluated on next-state values so warn lines up with secs_left.
  assign warn_cond = (state_d == RUNNING) && (secs_d <= SEC_W'(WARN_THRESH));

`ifdef WARN_BLINK_EN
  logic warn_cond_q;

  always_comb begin
    warn_d = 1'b0;
    if (warn_cond) begin
      if (!warn_cond_q)  warn_d = 1'b1;
      else if (sec_edge) warn_d = ~warn_q;
      else               warn_d = warn_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) warn_cond_q <= 1'b0;
    else          warn_cond_q <= warn_cond;
  end
`else
  assign warn_d = warn_cond;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      secs_q    <= '0;
      presc_q   <= '0;
      timeout_q <= 1'b0;
      warn_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      secs_q    <= secs_d;
      presc_q   <= presc_d;
      timeout_q <= timeout_d;
      warn_q    <= warn_d;
    end
  end

  assign bus.secs_left = secs_q;
  assign bus.running   = (state_q == RUNNING);
  assign bus.expired   = (state_q == EXPIRED);
  assign bus.timeout   = timeout_q;
  assign bus.warn      = warn_q;

  mastermind_bin2bcd #(
    .BIN_W (SEC_W)
  ) u_bin2bcd (
    .bin  (secs_q),
    .tens (bus.bcd_tens),
    .ones (bus.bcd_ones)
  );
endmodule

// File: tb/tb_mastermind_guess_timer.sv
// Scoreboard bench for mastermind_guess_timer (TICKS_PER_SEC=5, TIME_LIMIT=3, WARN_THRESH=1).
module tb_mastermind_guess_timer;
  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  mastermind_guess_timer_if #(.SEC_W(7)) tif ();
  mastermind_guess_timer_if #(.SEC_W(7)) tif47 ();

  mastermind_guess_timer #(
    .TICKS_PER_SEC (5),
    .TIME_LIMIT    (3),
    .WARN_THRESH   (1),
    .SEC_W         (7)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (tif)
  );

  mastermind_guess_timer #(
    .TICKS_PER_SEC (5),
    .TIME_LIMIT    (47),
    .WARN_THRESH   (1),
    .SEC_W         (7)
  ) dut47 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (tif47)
  );

  typedef struct packed {
    logic [6:0] secs;
    logic       run;
    logic       exp;
    logic       to;
    logic       warn;
    logic [3:0] tens;
    logic [3:0] ones;
  } obs_t;

  obs_t  exp_q[$];
  obs_t  obs_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One tick pulse followed by four idle cycles (tick every 5 clocks).
  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tif.tick = 1'b1;
      step();
      tif.tick = 1'b0;
      repeat (4) step();
    end
  endtask

  function automatic obs_t mk(input int s, input bit r, input bit e, input bit t, input bit w);
    obs_t o;
    o.secs = 7'(s);
    o.run  = r;
    o.exp  = e;
    o.to   = t;
    o.warn = w;
    o.tens = 4'(s / 10);
    o.ones = 4'(s % 10);
    return o;
  endfunction

  function automatic obs_t cur();
    obs_t o;
    o.secs = tif.secs_left;
    o.run  = tif.running;
    o.exp  = tif.expired;
    o.to   = tif.timeout;
    o.warn = tif.warn;
    o.tens = tif.bcd_tens;
    o.ones = tif.bcd_ones;
    return o;
  endfunction

  task automatic snap(input string n, input obs_t e);
    name_q.push_back(n);
    exp_q.push_back(e);
    obs_q.push_back(cur());
  endtask

  task automatic pulse_start();
    tif.start = 1'b1;
    step();
    tif.start = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e, o;
    string n;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    snap("reset_state", mk(0, 0, 0, 0, 0));
    do_ticks(6);
    snap("idle_ticks_ignored", mk(0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got %p expected %p", n, o, e);
      end
    end
  endtask

  task automatic test_countdown();
    obs_t e, o;
    string n;
    pulse_start();
    snap("start_loaded", mk(3, 1, 0, 0, 0));
    do_ticks(4);
    snap("no_dec_before_boundary", mk(3, 1, 0, 0, 0));
    do_ticks(1);
    snap("dec_to_2", mk(2, 1, 0, 0, 0));
    do_ticks(5);
    snap("dec_to_1_warn", mk(1, 1, 0, 0, 1));
    do_ticks(4);
    tif.tick = 1'b1;
    step();
    tif.tick = 1'b0;
    snap("expire_timeout", mk(0, 0, 1, 1, 0));
    step();
    snap("timeout_one_cycle", mk(0, 0, 1, 0, 0));
    do_ticks(10);
    snap("expired_holds", mk(0, 0, 1, 0, 0));
    pulse_start();
    snap("restart_from_expired", mk(3, 1, 0, 0, 0));
    tif.guess_done = 1'b1;
    step();
    tif.guess_done = 1'b0;
    snap("guess_done_freezes", mk(3, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got %p expected %p", n, o, e);
      end
    end
  endtask

  task automatic test_pause();
    obs_t e, o;
    string n;
    pulse_start();
    do_ticks(5);
    do_ticks(2);
    tif.pause = 1'b1;
    step();
    snap("paused_holds", mk(2, 0, 0, 0, 0));
    do_ticks(20);
    snap("pause_20_ticks", mk(2, 0, 0, 0, 0));
    tif.pause = 1'b0;
    step();
    snap("resume_running", mk(2, 1, 0, 0, 0));
    do_ticks(2);
    snap("prescaler_held", mk(2, 1, 0, 0, 0));
    do_ticks(1);
    snap("dec_after_resume", mk(1, 1, 0, 0, 1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got %p expected %p", n, o, e);
      end
    end
  endtask

  task automatic test_guess_done_expiring();
    obs_t e, o;
    string n;
    pulse_start();
    do_ticks(14);
    tif.tick       = 1'b1;
    tif.guess_done = 1'b1;
    step();
    tif.tick       = 1'b0;
    tif.guess_done = 1'b0;
    snap("gd_wins_expiry", mk(1, 0, 0, 0, 0));
    step();
    snap("gd_no_timeout", mk(1, 0, 0, 0, 0));
    tif.guess_done = 1'b1;
    step();
    tif.guess_done = 1'b0;
    do_ticks(6);
    snap("idle_ignores_gd_tick", mk(1, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got %p expected %p", n, o, e);
      end
    end
  endtask

  task automatic test_start_boundary();
    obs_t e, o;
    string n;
    pulse_start();
    do_ticks(9);
    tif.tick  = 1'b1;
    tif.start = 1'b1;
    step();
    tif.tick  = 1'b0;
    tif.start = 1'b0;
    snap("start_wins_boundary", mk(3, 1, 0, 0, 0));
    repeat (4) step();
    do_ticks(4);
    snap("prescaler_cleared", mk(3, 1, 0, 0, 0));
    do_ticks(1);
    snap("full_second_after", mk(2, 1, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got %p expected %p", n, o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, o;
    string n;
    pulse_start();
    do_ticks(5);
    snap("before_reset", mk(2, 1, 0, 0, 0));
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    snap("reset_mid_count", mk(0, 0, 0, 0, 0));
    do_ticks(10);
    snap("ticks_after_reset", mk(0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got %p expected %p", n, o, e);
      end
    end
  endtask

  task automatic test_bcd47();
    tif47.start = 1'b1;
    step();
    tif47.start = 1'b0;
    checks++;
    if (tif47.secs_left !== 7'd47) begin
      errors++;
      $display("FAIL bcd47_secs: got %0d expected 47", tif47.secs_left);
    end
    checks++;
    if (tif47.bcd_tens !== 4'd4) begin
      errors++;
      $display("FAIL bcd47_tens: got %0d expected 4", tif47.bcd_tens);
    end
    checks++;
    if (tif47.bcd_ones !== 4'd7) begin
      errors++;
      $display("FAIL bcd47_ones: got %0d expected 7", tif47.bcd_ones);
    end
  endtask

  initial begin
    tif.tick         = 1'b0;
    tif.start        = 1'b0;
    tif.pause        = 1'b0;
    tif.guess_done   = 1'b0;
    tif47.tick       = 1'b0;
    tif47.start      = 1'b0;
    tif47.pause      = 1'b0;
    tif47.guess_done = 1'b0;
    repeat (2) step();
    test_reset();
    test_countdown();
    test_pause();
    test_guess_done_expiring();
    test_start_boundary();
    test_reset_mid();
    test_bcd47();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
